uart_tx_framer: RTL and testbench

- Parametrised UART transmitter with an internal baud-tick divider and a valid/ready byte handshake.
- Data width, stop-bit count and bit period are configurable; optional parity is selected by a compile-time macro.
- Runs on the system clock.
- Sits between the coincidence-count packetiser and the board UART pin; it replaces free-running, baud-clocked serialisation with framed, flow-controlled transmission.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_baud_tick.sv | 41 ++++
 rtl/uart_tx_framer.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_framer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared types and helpers for the UART transmit/receive blocks
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic TX_IDLE_LEVEL = 1'b1;

  // Frame length in bit periods: start + payload + optional parity + stop.
  function automatic int frame_bits(input int data_bits, input int stop_bits, input bit parity_en);
    return 1 + data_bits + (parity_en ? 1 : 0) + stop_bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// uart_baud_tick : bit-period divider, one-cycle tick on wrap, sync clear
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || (cnt_q == C_LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_tx_framer.sv
// ============================================================================
// uart_tx_framer : framed UART transmitter with valid/ready byte handshake
//                  Optional parity bit enabled by macro UART_TX_PARITY_EN.
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int IDX_W = $clog2(DATA_BITS);

  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
    $error("uart_tx_framer: DATA_BITS must be 5..9");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
    $error("uart_tx_framer: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_framer: CLKS_PER_BIT must be at least 2");
  end
  if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_parity_odd
    $error("uart_tx_framer: PARITY_ODD must be 0 or 1");
  end

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q,   idx_d;
  logic                 tx_q,    tx_d;
  logic                 busy_q,  busy_d;
  logic                 done_q,  done_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif
  logic                 accept;
  logic                 tick;

  assign ready  = (state_q == IDLE) && !rst;
  assign accept = valid && ready;

  // Divider restarts on acceptance so the start bit is a full period.
  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = TX_IDLE_LEVEL;
        if (accept) begin
          state_d  = START;
          shift_d  = data;
          idx_d    = '0;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d = (^data) ^ (PARITY_ODD != 0);
`endif
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            idx_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = TX_IDLE_LEVEL;
`endif
          end else begin
            // Next bit is read from the unshifted register to stay one step ahead.
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            idx_d   = idx_q + IDX_W'(1);
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          idx_d   = '0;
          tx_d    = TX_IDLE_LEVEL;
        end
      end
`endif
      STOP: begin
        tx_d = TX_IDLE_LEVEL;
        if (tick) begin
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            state_d = IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        tx_d    = TX_IDLE_LEVEL;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      tx_q     <= TX_IDLE_LEVEL;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_framer.sv
// ============================================================================
// tb_uart_tx_framer : three framer configurations against a frame-level model
// Rev 1.0           : initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_framer;

  int   checks = 0;
  int   errors = 0;
  logic clk    = 1'b0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int cfg, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cfg%0d @%0t: got 0x%0h expected 0x%0h", nm, cfg, $time, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int C    = 4;
    localparam int D    = (gi == 2) ? 5 : 8;
    localparam int S    = (gi == 1) ? 2 : 1;
    localparam int PODD = (gi == 1) ? 1 : 0;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
    localparam logic [15:0] EXP_SEQ = (gi == 0) ? 16'b01010010101 :
                                      (gi == 1) ? 16'b011100000011 : 16'b00110111;
    localparam int EXP_CYC = (gi == 0) ? 44 : (gi == 1) ? 48 : 32;
`else
    localparam int P = 0;
    localparam logic [15:0] EXP_SEQ = (gi == 0) ? 16'b0101001011 :
                                      (gi == 1) ? 16'b01110000011 : 16'b0011011;
    localparam int EXP_CYC = (gi == 0) ? 40 : (gi == 1) ? 44 : 28;
`endif
    localparam int NB = 1 + D + P + S;
    localparam logic [8:0] FIRST_BYTE = (gi == 0) ? 9'h0A5 : (gi == 1) ? 9'h007 : 9'h016;
    localparam logic [8:0] AFTER_RST  = 9'h03C;

    logic         rst;
    logic [D-1:0] data;
    logic         valid;
    logic         ready;
    logic         tx;
    logic         busy;
    logic         done;
    bit           fin_b = 1'b0;

    uart_tx_framer #(
      .DATA_BITS    (D),
      .STOP_BITS    (S),
      .CLKS_PER_BIT (C),
      .PARITY_ODD   (PODD)
    ) dut (
      .clk   (clk),
      .rst   (rst),
      .data  (data),
      .valid (valid),
      .ready (ready),
      .tx    (tx),
      .busy  (busy),
      .done  (done)
    );

    // Frame-level model: a frame is a list of NB line levels, each held C cycles.
    int   m_cnt  = 0;
    bit   m_act  = 1'b0;
    bit   m_done = 1'b0;
    logic m_fr [0:15];

    always @(posedge clk) begin
      m_done = 1'b0;
      if (rst) begin
        m_act = 1'b0;
      end else if (m_act) begin
        m_cnt++;
        if (m_cnt == NB * C) begin
          m_act  = 1'b0;
          m_done = 1'b1;
        end
      end else if (valid) begin
        m_fr[0] = 1'b0;
        for (int i = 0; i < D; i++) m_fr[1 + i] = data[i];
        if (P == 1) m_fr[1 + D] = (^data) ^ (PODD != 0);
        for (int i = 0; i < S; i++) m_fr[1 + D + P + i] = 1'b1;
        m_act = 1'b1;
        m_cnt = 0;
      end
      #1;
      chk("tx",    gi, 32'(tx),    32'(m_act ? m_fr[m_cnt / C] : 1'b1));
      chk("busy",  gi, 32'(busy),  32'(m_act));
      chk("done",  gi, 32'(done),  32'(m_done));
      chk("ready", gi, 32'(ready), 32'(!m_act && !rst));
    end

    // Sends one byte, scrambles data afterwards, samples each bit mid-period
    // and measures acceptance-to-done latency. Entered and left on a negedge.
    task automatic send_measure(input logic [D-1:0] b, output int lat,
                                output logic [15:0] cap, output logic rdy_at_done);
      lat = -1;
      cap = '0;
      rdy_at_done = 1'b0;
      for (int w = 0; w < 300 && ready !== 1'b1; w++) @(negedge clk);
      valid = 1'b1;
      data  = b;
      @(negedge clk);
      valid = 1'b0;
      for (int k = 1; k < 300; k++) begin
        data = D'($urandom);
        if (((k - 1) % C) == 1) cap = {cap[14:0], tx};
        if (done === 1'b1) begin
          lat = k - 1;
          rdy_at_done = ready;
          break;
        end
        @(negedge clk);
      end
    endtask

    initial begin
      int          lat;
      logic [15:0] cap;
      logic        rdy;
      bit          tog;
      rst   = 1'b1;
      valid = 1'b0;
      data  = '0;
      repeat (3) @(negedge clk);
      chk("reset_tx",    gi, 32'(tx),    32'd1);
      chk("reset_ready", gi, 32'(ready), 32'd0);
      chk("reset_busy",  gi, 32'(busy),  32'd0);
      chk("reset_done",  gi, 32'(done),  32'd0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", gi, 32'(ready), 32'd1);

      send_measure(FIRST_BYTE[D-1:0], lat, cap, rdy);
      chk("first_frame_bits",    gi, 32'(cap), 32'(EXP_SEQ));
      chk("first_frame_latency", gi, 32'(lat), 32'(EXP_CYC));
      chk("ready_with_done",     gi, 32'(rdy), 32'd1);

      for (int n = 0; n < 400; n++) begin
        @(negedge clk);
        valid = ($urandom_range(0, 3) != 0);
        data  = D'($urandom);
      end

      // Valid held high continuously, alternating all-zeros / all-ones frames.
      tog = 1'b0;
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        valid = 1'b1;
        if (ready === 1'b1) tog = ~tog;
        data = tog ? '1 : '0;
      end
      @(negedge clk);
      valid = 1'b0;

      // Abort a frame during data bit 3 with an asynchronous reset.
      for (int w = 0; w < 300 && ready !== 1'b1; w++) @(negedge clk);
      valid = 1'b1;
      data  = D'($urandom);
      @(negedge clk);
      valid = 1'b0;
      repeat (17) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_tx",    gi, 32'(tx),    32'd1);
      chk("abort_busy",  gi, 32'(busy),  32'd0);
      chk("abort_ready", gi, 32'(ready), 32'd0);
      chk("abort_done",  gi, 32'(done),  32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      send_measure(AFTER_RST[D-1:0], lat, cap, rdy);
      chk("post_reset_latency", gi, 32'(lat), 32'(EXP_CYC));
      repeat (4) @(negedge clk);
      fin_b = 1'b1;
    end
  end

  initial begin
    for (int t = 0; t < 20000 && !(g_cfg[0].fin_b && g_cfg[1].fin_b && g_cfg[2].fin_b); t++)
      @(posedge clk);
    if (!(g_cfg[0].fin_b && g_cfg[1].fin_b && g_cfg[2].fin_b)) begin
      checks++;
      errors++;
      $display("FAIL timeout: stimulus did not complete within the cycle budget");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
